wb_csr_bank: RTL and testbench
==============================

# wb_csr_bank

Parametrised Wishbone-slave control/status register bank for the accelerator. It holds NREGS word registers at a configurable base address: a control register with a self-clearing start pulse, a status register with sticky write-1-to-clear event bits, and NREGS-2 plain read/write configuration registers exported as a flat bus to the compute datapath. It also raises a maskable interrupt when the datapath reports completion.

## Interface
- DWIDTH, 32: data and address width; must be a multiple of 8.
- NREGS, 8: number of registers; minimum 3.
- ADDR_LSB, 2: byte-to-word shift; register index = wbs_adr_i[ADDR_LSB +: AW], AW = clog2(NREGS).
- BASE_ADDR, 32'h3000_0000: bank base; bits below ADDR_LSB+AW are ignored.

Ports:
- wb_clk_i  in  1  single clock; reset is synchronous and active-high.
- wb_rst_i  in  1  synchronous reset, active-high.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle and write-enable.
- wbs_sel_i  in  DWIDTH/8  byte selects.
- wbs_adr_i, wbs_dat_i  in  DWIDTH each  byte address and write data.
- wbs_ack_o  out  1  transfer acknowledge.
- wbs_dat_o  out  DWIDTH  registered read data.
- done_i  in  1  datapath completion; any high cycle counts as an event.
- busy_i  in  1  datapath busy level.
- start_o  out  1  one-cycle start pulse.
- irq_o  out  1  interrupt level.
- cfg_o  out  (NREGS-2)*DWIDTH  registers 2..NREGS-1, concatenated; reg 2 is in the LSBs.

## Operation
Register map (index):
- 0 CTRL (read/write):
  - bit0 START: writing 1 fires start_o; the bit always reads 0.
  - bit1 IRQ_EN.
  - Other bits are plain storage.
- 1 STATUS:
  - bit0 BUSY: read-only, mirrors busy_i.
  - bit1 DONE: sticky, write-1-to-clear.
  - bit2 OVERRUN: sticky, write-1-to-clear.
  - Other bits read 0; writes to them are ignored.
- 2..NREGS-1 CFG: plain read/write, driven continuously onto cfg_o.

Address decode and access rules:
- Hit: wbs_adr_i[DWIDTH-1:ADDR_LSB+AW] == BASE_ADDR[DWIDTH-1:ADDR_LSB+AW] and index < NREGS.
- Miss: the access is still acked, reads return 0 and writes have no effect.
- Writes honour wbs_sel_i per byte for every writable field. START, DONE-clear and OVERRUN-clear act only when their byte lane (lane 0) is selected.

Start behaviour:
- A START write while busy_i=1 does not pulse start_o. It sets OVERRUN instead.

Sticky-bit behaviour:
- DONE is set on any cycle with done_i=1.
- If a clear and a set land in the same cycle, the set wins (bit ends at 1). The same applies to OVERRUN.

Interrupt:
- irq_o = DONE & IRQ_EN, driven from registers with no extra flop.

Reset (wb_rst_i=1 at a clock edge):
- All registers clear to 0.
- wbs_ack_o=0, wbs_dat_o=0, start_o=0, irq_o=0, cfg_o=0.
- Reset mid-transfer drops the pending ack. The master must restart the cycle.

## Timing
- A transfer is valid when wbs_cyc_i & wbs_stb_i.
- Ack:
  - wbs_ack_o rises one cycle after valid is first seen, provided ack is currently low.
  - Ack stays high for exactly one cycle.
  - Holding stb high therefore gives at most one transfer per 2 cycles.
- Read data:
  - wbs_dat_o is registered in the same edge that raises ack and holds until the next read.
  - Write transfers leave wbs_dat_o unchanged.
- STATUS read sampling: BUSY and the sticky bits are captured at the edge that raises ack.
  - A done_i that arrives on that same edge is not visible in this read.
  - That done_i is still latched and shows on the next read.
- Write timing:
  - Write effects land on the edge that raises ack.
  - cfg_o and IRQ_EN update in the ack cycle.
  - start_o is high exactly during the ack cycle.
- irq_o timing:
  - Rises the cycle after the done_i edge when IRQ_EN=1.
  - Falls in the ack cycle of the W1C write to DONE.

## Test plan
- After reset, read index 0..7 at BASE_ADDR+4*i: every read returns 0, each ack lasts one cycle, and start_o, irq_o and cfg_o stay 0.
- Write 0xA5A5_1234 to index 3 with sel=4'b0101, then read it back:
  - Readback is 0x00A5_0034.
  - cfg_o[63:32] equals the readback value.
- Write CTRL=0x3 with busy_i=0:
  - start_o is high for exactly one cycle, coincident with ack.
  - A CTRL readback returns 0x2.
- Pulse done_i for 1 cycle with IRQ_EN=1:
  - irq_o rises the next cycle.
  - A STATUS read returns 0x2.
  - Write STATUS=0x2: irq_o falls in the ack cycle.
  - Repeat the W1C with done_i asserted on the write's edge: DONE stays 1.
- Write CTRL bit0 while busy_i=1:
  - No start_o pulse.
  - STATUS reads 0x5.
  - Write STATUS=0x4, then STATUS reads 0x1.
- Access BASE_ADDR+0x100 (miss), and BASE_ADDR+0x20 with NREGS=8 (also a miss):
  - Both are acked and reads return 0.
  - All registers are unchanged.
- Assert reset mid-transfer (stb high, before ack): ack stays 0 and the bank returns to reset values.

Source files
------------

// File: rtl/wb_csr_bank.sv
// Wishbone-slave control/status register bank: CTRL with self-clearing start,
// STATUS with sticky write-1-to-clear events, and plain CFG registers exported
// as a flat bus. Every transfer (hit or miss) is acked one cycle after it is seen.
`timescale 1ns/1ps
module wb_csr_bank #(
  parameter int                DWIDTH    = 32,
  parameter int                NREGS     = 8,
  parameter int                ADDR_LSB  = 2,
  parameter logic [DWIDTH-1:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        wbs_stb_i,
  input  logic                        wbs_cyc_i,
  input  logic                        wbs_we_i,
  input  logic [DWIDTH/8-1:0]         wbs_sel_i,
  input  logic [DWIDTH-1:0]           wbs_adr_i,
  input  logic [DWIDTH-1:0]           wbs_dat_i,
  output logic                        wbs_ack_o,
  output logic [DWIDTH-1:0]           wbs_dat_o,
  input  logic                        done_i,
  input  logic                        busy_i,
  output logic                        start_o,
  output logic                        irq_o,
  output logic [(NREGS-2)*DWIDTH-1:0] cfg_o
);

  localparam int AW   = $clog2(NREGS);
  localparam int NB   = DWIDTH / 8;
  localparam int NCFG = NREGS - 2;

  logic              ack_reg;
  logic [DWIDTH-1:0] dat_reg;
  logic              start_reg;
  logic [DWIDTH-1:0] ctrl_reg;
  logic              done_reg;
  logic              overrun_reg;

  logic [AW-1:0]     reg_idx;
  logic              base_hit;
  logic              idx_ok;
  logic              hit;
  logic              xfer;
  logic              wr_en;
  logic              rd_en;
  logic              ctrl_sel;
  logic              status_sel;
  logic              start_req;
  logic              done_clr;
  logic              overrun_clr;
  logic [DWIDTH-1:0] ctrl_wdata;
  logic [DWIDTH-1:0] rd_data;
  logic              unused_adr_bits;

  // Address decode: upper bits must match the base, index must be populated.
  assign reg_idx  = wbs_adr_i[ADDR_LSB +: AW];
  assign base_hit = (wbs_adr_i[DWIDTH-1:ADDR_LSB+AW] == BASE_ADDR[DWIDTH-1:ADDR_LSB+AW]);

  generate
    if (NREGS == (1 << AW)) begin : g_idx_full
      assign idx_ok = 1'b1;
    end else begin : g_idx_part
      assign idx_ok = (reg_idx < AW'(NREGS));
    end
  endgenerate

  assign hit             = base_hit & idx_ok;
  assign unused_adr_bits = &{1'b0, wbs_adr_i[ADDR_LSB-1:0]};

  // A transfer is taken on the edge that raises ack; ack is never held two cycles.
  assign xfer  = wbs_cyc_i & wbs_stb_i & ~ack_reg;
  assign wr_en = xfer & wbs_we_i & hit;
  assign rd_en = xfer & ~wbs_we_i;

  assign ctrl_sel    = wr_en & (reg_idx == AW'(0));
  assign status_sel  = wr_en & (reg_idx == AW'(1));
  assign start_req   = ctrl_sel & wbs_sel_i[0] & wbs_dat_i[0];
  assign done_clr    = status_sel & wbs_sel_i[0] & wbs_dat_i[1];
  assign overrun_clr = status_sel & wbs_sel_i[0] & wbs_dat_i[2];

  // START is never stored, so the bit always reads back as 0.
  assign ctrl_wdata = {wbs_dat_i[DWIDTH-1:1], 1'b0};

  // Acknowledge generation; reset drops any pending ack.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) ack_reg <= 1'b0;
    else          ack_reg <= xfer;
  end

  // Read data register: loaded only by read transfers, held otherwise.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)   dat_reg <= '0;
    else if (rd_en) dat_reg <= rd_data;
  end

  // One-cycle start pulse, suppressed while the datapath is busy.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) start_reg <= 1'b0;
    else          start_reg <= start_req & ~busy_i;
  end

  // Sticky DONE: a new event in the same cycle as a clear wins.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) done_reg <= 1'b0;
    else          done_reg <= done_i | (done_reg & ~done_clr);
  end

  // Sticky OVERRUN: set by a start request while busy; set wins over clear.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) overrun_reg <= 1'b0;
    else          overrun_reg <= (start_req & busy_i) | (overrun_reg & ~overrun_clr);
  end

  // CTRL register with per-byte write enables.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ctrl_reg <= '0;
    end else if (ctrl_sel) begin
      for (int b = 0; b < NB; b++) begin
        if (wbs_sel_i[b]) ctrl_reg[b*8 +: 8] <= ctrl_wdata[b*8 +: 8];
      end
    end
  end

  // CFG registers, one per index 2..NREGS-1, each driving its cfg_o slice.
  genvar gi;
  generate
    for (gi = 0; gi < NCFG; gi++) begin : g_cfg
      logic [DWIDTH-1:0] cfg_reg;
      logic              cfg_sel;

      assign cfg_sel = wr_en & (reg_idx == AW'(gi + 2));

      // Byte-lane write into this configuration register.
      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
          cfg_reg <= '0;
        end else if (cfg_sel) begin
          for (int b = 0; b < NB; b++) begin
            if (wbs_sel_i[b]) cfg_reg[b*8 +: 8] <= wbs_dat_i[b*8 +: 8];
          end
        end
      end

      assign cfg_o[gi*DWIDTH +: DWIDTH] = cfg_reg;
    end
  endgenerate

  // Read mux; misses read as zero, STATUS samples the current sticky state.
  always_comb begin
    rd_data = '0;
    if (hit) begin
      if (reg_idx == AW'(0)) begin
        rd_data = ctrl_reg;
      end else if (reg_idx == AW'(1)) begin
        rd_data[2:0] = {overrun_reg, done_reg, busy_i};
      end else begin
        for (int i = 0; i < NCFG; i++) begin
          if (reg_idx == AW'(i + 2)) rd_data = cfg_o[i*DWIDTH +: DWIDTH];
        end
      end
    end
  end

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = dat_reg;
  assign start_o   = start_reg;
  assign irq_o     = done_reg & ctrl_reg[1];

endmodule

// File: tb/tb_wb_csr_bank.sv
// Self-checking bench for wb_csr_bank: directed steps followed by random
// transfers, all compared against an abstract register-map model.
`timescale 1ns/1ps
module tb_wb_csr_bank;

  localparam int          NR   = 8;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic         stb, cyc, we;
  logic [3:0]   sel;
  logic [31:0]  adr, wdat;
  logic         ack;
  logic [31:0]  rdat;
  logic         done_i, busy;
  logic         start, irq;
  logic [191:0] cfg;

  int vectors = 0;
  int miscompares = 0;

  // Abstract model of the register map.
  logic [31:0] m_reg [NR];
  bit          m_done, m_ovr;
  logic [31:0] m_last_rd;

  wb_csr_bank dut (
    .wb_clk_i (clk),    .wb_rst_i (rst),
    .wbs_stb_i(stb),    .wbs_cyc_i(cyc),   .wbs_we_i(we),
    .wbs_sel_i(sel),    .wbs_adr_i(adr),   .wbs_dat_i(wdat),
    .wbs_ack_o(ack),    .wbs_dat_o(rdat),
    .done_i   (done_i), .busy_i   (busy),
    .start_o  (start),  .irq_o    (irq),   .cfg_o(cfg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hit(input logic [31:0] a);
    return ((a >> 5) == (BASE >> 5));
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a >> 2) % NR);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!m_hit(a)) return 32'h0;
    case (m_idx(a))
      0:       return m_reg[0];
      1:       return {29'h0, m_ovr, m_done, busy};
      default: return m_reg[m_idx(a)];
    endcase
  endfunction

  function automatic logic [191:0] m_cfg();
    logic [191:0] v;
    for (int i = 2; i < NR; i++) v[(i-2)*32 +: 32] = m_reg[i];
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NR; i++) m_reg[i] = 32'h0;
    m_done = 0; m_ovr = 0; m_last_rd = 32'h0;
  endtask

  // One bus cycle; captures DUT outputs during the ack cycle, then checks ack drops.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input bit dedge, output logic [31:0] rd, output logic st, output logic iq,
                     output logic [191:0] cf);
    int n = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
    if (dedge) done_i = 1;
    do begin
      @(posedge clk); #1;
      done_i = 0;
      n++;
    end while (!ack && n < 8);
    chk("ack_seen", ack, 1'b1);
    rd = rdat; st = start; iq = irq; cf = cfg;
    @(negedge clk);
    cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1;
    chk("ack_one_cycle", ack, 1'b0);
    chk("start_one_cycle", start, 1'b0);
    $display("%s adr=%08h dat=%08h sel=%b busy=%0d done_edge=%0d rd=%08h start=%0d irq=%0d",
             w ? "WR" : "RD", a, d, s, busy, dedge, rd, st, iq);
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input bit dedge);
    logic [31:0] rd; logic st, iq; logic [191:0] cf;
    bit exp_start = 0;
    if (m_hit(a)) begin
      case (m_idx(a))
        0: begin
          m_reg[0] = merge(m_reg[0], d, s) & ~32'h1;
          if (s[0] && d[0]) begin
            if (busy) m_ovr = 1; else exp_start = 1;
          end
        end
        1: begin
          if (s[0] && d[1]) m_done = 0;
          if (s[0] && d[2]) m_ovr = 0;
        end
        default: m_reg[m_idx(a)] = merge(m_reg[m_idx(a)], d, s);
      endcase
    end
    if (dedge) m_done = 1;
    bus(1'b1, a, d, s, dedge, rd, st, iq, cf);
    chk("wr_start", st, exp_start);
    chk("wr_irq", iq, m_done & m_reg[0][1]);
    chk("wr_cfg", cf, m_cfg());
    chk("wr_dat_hold", rd, m_last_rd);
  endtask

  task automatic do_rd(input logic [31:0] a, input bit dedge);
    logic [31:0] rd; logic st, iq; logic [191:0] cf;
    logic [31:0] exp_rd = m_read(a);
    if (dedge) m_done = 1;
    bus(1'b0, a, 32'h0, 4'hF, dedge, rd, st, iq, cf);
    m_last_rd = exp_rd;
    chk("rd_data", rd, exp_rd);
    chk("rd_start", st, 1'b0);
    chk("rd_irq", iq, m_done & m_reg[0][1]);
    chk("rd_cfg", cf, m_cfg());
  endtask

  task automatic pulse_done();
    @(negedge clk); done_i = 1;
    @(posedge clk); #1;
    m_done = 1;
    chk("irq_rise", irq, m_reg[0][1]);
    @(negedge clk); done_i = 0;
  endtask

  initial begin
    logic [31:0] a;
    int k;
    rst = 1; stb = 0; cyc = 0; we = 0; sel = 0; adr = 0; wdat = 0; done_i = 0; busy = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack, 1'b0);
    chk("rst_dat", rdat, 32'h0);
    chk("rst_start", start, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_cfg", cfg, 192'h0);
    @(negedge clk); rst = 0;

    // All registers read zero after reset.
    for (int i = 0; i < NR; i++) do_rd(BASE + 32'(4 * i), 0);

    // Partial byte write to CFG index 3.
    do_wr(BASE + 32'hC, 32'hA5A5_1234, 4'b0101, 0);
    do_rd(BASE + 32'hC, 0);
    chk("cfg3_readback", rdat, 32'h00A5_0034);
    chk("cfg3_bus", cfg[63:32], 32'h00A5_0034);

    // Start pulse with IRQ enable.
    busy = 0;
    do_wr(BASE, 32'h3, 4'hF, 0);
    do_rd(BASE, 0);
    chk("ctrl_readback", rdat, 32'h2);

    // DONE event, interrupt, and W1C with and without a colliding event.
    pulse_done();
    do_rd(BASE + 32'h4, 0);
    chk("status_done", rdat, 32'h2);
    do_wr(BASE + 32'h4, 32'h2, 4'hF, 0);
    chk("irq_cleared", irq, 1'b0);
    pulse_done();
    do_wr(BASE + 32'h4, 32'h2, 4'hF, 1);
    do_rd(BASE + 32'h4, 0);
    chk("status_set_wins", rdat, 32'h2);
    do_wr(BASE + 32'h4, 32'h2, 4'hF, 0);

    // Start request while busy becomes OVERRUN.
    busy = 1;
    do_wr(BASE, 32'h3, 4'hF, 0);
    do_rd(BASE + 32'h4, 0);
    chk("status_overrun", rdat, 32'h5);
    do_wr(BASE + 32'h4, 32'h4, 4'hF, 0);
    do_rd(BASE + 32'h4, 0);
    chk("status_ovr_clr", rdat, 32'h1);
    busy = 0;

    // Misses are acked, read zero and change nothing.
    do_wr(BASE + 32'h100, 32'hFFFF_FFFF, 4'hF, 0);
    do_wr(BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, 0);
    do_rd(BASE + 32'h100, 0);
    chk("miss_100", rdat, 32'h0);
    do_rd(BASE + 32'h20, 0);
    chk("miss_20", rdat, 32'h0);
    for (int i = 0; i < NR; i++) do_rd(BASE + 32'(4 * i), 0);

    // Randomized traffic against the model.
    for (int it = 0; it < 60; it++) begin
      busy = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) pulse_done();
      k = $urandom_range(0, 9);
      if (k < 8)       a = BASE + 32'(4 * k) + 32'($urandom_range(0, 3));
      else if (k == 8) a = BASE + 32'h100;
      else             a = BASE + 32'h20 + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1)
        do_wr(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 5) == 0);
      else
        do_rd(a, $urandom_range(0, 5) == 0);
    end
    busy = 0;

    // Reset in the middle of a transfer drops the ack and clears the bank.
    do_wr(BASE + 32'h8, 32'hDEAD_BEEF, 4'hF, 0);
    do_wr(BASE, 32'h2, 4'hF, 0);
    pulse_done();
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = BASE + 32'h8; rst = 1;
    @(posedge clk); #1;
    chk("midrst_ack", ack, 1'b0);
    chk("midrst_dat", rdat, 32'h0);
    chk("midrst_cfg", cfg, 192'h0);
    chk("midrst_irq", irq, 1'b0);
    chk("midrst_start", start, 1'b0);
    @(negedge clk); rst = 0; cyc = 0; stb = 0;
    @(posedge clk); #1;
    chk("midrst_ack_after", ack, 1'b0);
    m_reset();
    do_rd(BASE + 32'h8, 0);
    do_rd(BASE, 0);
    do_rd(BASE + 32'h4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
